// File: rtl/memspace_pkg.sv
// Shared definitions for the sequencer configuration store: FSM state
// encoding, header bit positions and frame geometry helpers.
// Optional feature macro: MEMSPACE_CHECKSUM_EN (adds a trailing XOR byte).
package memspace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // Header byte layout: bit 7 picks register space, bits 6:0 carry the channel.
    localparam int HDR_SEL_BIT = 7;
    localparam int HDR_CH_MSB  = 6;
    localparam int HDR_CH_W    = HDR_CH_MSB + 1;

`ifdef MEMSPACE_CHECKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif

    // Number of address bytes carried in a frame.
    function automatic int frame_ab(input int addr_w);
        return (addr_w + 7) / 8;
    endfunction

    // Number of data bytes: wide enough for either a RAM word or a register.
    function automatic int frame_db(input int data_w, input int reg_w);
        return (((data_w > reg_w) ? data_w : reg_w) + 7) / 8;
    endfunction

    // Total frame length in bytes, including the optional checksum byte.
    function automatic int frame_fl(input int ab, input int db);
        return 1 + ab + db + CHK_BYTES;
    endfunction

endpackage

// File: rtl/uart_frame_assembler.sv
// Collects framed UART bytes into a shift register, drops stalled partial
// frames after an idle timeout and presents the decoded frame for one cycle.
// Checksum byte present only when MEMSPACE_CHECKSUM_EN is defined.
import memspace_pkg::*;

module uart_frame_assembler #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 12,
    parameter int REG_W       = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               byte_valid,
    input  logic [7:0]                         byte_data,
    output logic                               frame_valid,
    output logic                               frame_sel,
    output logic [HDR_CH_W-1:0]                frame_ch,
    output logic [frame_ab(ADDR_W)*8-1:0]      frame_addr,
    output logic [frame_db(DATA_W, REG_W)*8-1:0] frame_data,
    output logic                               chk_ok,
    output logic                               timeout_drop
);

    localparam int AB     = frame_ab(ADDR_W);
    localparam int DB     = frame_db(DATA_W, REG_W);
    localparam int FL     = frame_fl(AB, DB);
    localparam int BUF_W  = FL * 8;
    localparam int CNT_W  = $clog2(FL + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    state_t              state_reg;
    logic [CNT_W-1:0]    byte_cnt_reg;
    logic [IDLE_W-1:0]   idle_cnt_reg;
    logic [BUF_W-1:0]    shift_reg;
    logic [7:0]          xor_reg;
    logic                timeout_drop_reg;
    logic [7:0]          header;

    // Frame FSM: header starts a frame, the last byte moves to COMMIT, and a
    // byte seen during COMMIT is taken straight away as the next header.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            byte_cnt_reg     <= '0;
            idle_cnt_reg     <= '0;
            shift_reg        <= '0;
            xor_reg          <= '0;
            timeout_drop_reg <= 1'b0;
        end else begin
            timeout_drop_reg <= 1'b0;
            case (state_reg)
                IDLE, COMMIT: begin
                    if (byte_valid) begin
                        shift_reg    <= {shift_reg[BUF_W-9:0], byte_data};
                        xor_reg      <= byte_data;
                        byte_cnt_reg <= CNT_W'(1);
                        idle_cnt_reg <= '0;
                        state_reg    <= COLLECT;
                    end else begin
                        state_reg    <= IDLE;
                    end
                end
                COLLECT: begin
                    if (byte_valid) begin
                        shift_reg    <= {shift_reg[BUF_W-9:0], byte_data};
                        xor_reg      <= xor_reg ^ byte_data;
                        idle_cnt_reg <= '0;
                        if (byte_cnt_reg == CNT_W'(FL - 1)) begin
                            byte_cnt_reg <= '0;
                            state_reg    <= COMMIT;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
                        end
                    end else if (idle_cnt_reg == IDLE_W'(TIMEOUT_CYC - 1)) begin
                        // Line went quiet mid-frame: resynchronise on the next byte.
                        byte_cnt_reg     <= '0;
                        idle_cnt_reg     <= '0;
                        timeout_drop_reg <= 1'b1;
                        state_reg        <= IDLE;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign header       = shift_reg[BUF_W-1 -: 8];
    assign frame_valid  = (state_reg == COMMIT);
    assign frame_sel    = header[HDR_SEL_BIT];
    assign frame_ch     = header[HDR_CH_MSB:0];
    assign frame_addr   = shift_reg[BUF_W-9 -: AB*8];
    assign frame_data   = shift_reg[CHK_BYTES*8 +: DB*8];
    // Without a checksum byte every frame is accepted as consistent.
    assign chk_ok       = (xor_reg == 8'h00) || (CHK_BYTES == 0);
    assign timeout_drop = timeout_drop_reg;

endmodule

// File: rtl/seq_memory_space.sv
// Sequencer configuration store: per-channel sequence RAMs with registered
// read ports, a register bank, range checking and a dropped-frame counter.
// Optional feature macro: MEMSPACE_CHECKSUM_EN (trailing XOR byte per frame).
import memspace_pkg::*;

module seq_memory_space #(
    parameter int NUM_CH      = 8,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 12,
    parameter int NUM_REGS    = 9,
    parameter int REG_W       = 16,
    parameter int REG_DEFAULT = 10,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       uart_rx_wr_en,
    input  logic [7:0]                 uart_rx_data,
    input  logic [NUM_CH*ADDR_W-1:0]   seq_addr,
    output logic [NUM_CH*DATA_W-1:0]   memout,
    output logic [NUM_REGS*REG_W-1:0]  reg_out,
    output logic                       wr_done,
    output logic [7:0]                 frame_err_cnt
);

    localparam int AB = frame_ab(ADDR_W);
    localparam int DB = frame_db(DATA_W, REG_W);

    logic                 frame_valid;
    logic                 frame_sel;
    logic [HDR_CH_W-1:0]  frame_ch;
    logic [AB*8-1:0]      frame_addr;
    logic [DB*8-1:0]      frame_data;
    logic                 chk_ok;
    logic                 timeout_drop;

    logic                 addr_hi_zero;
    logic                 ch_ok;
    logic                 reg_ok;
    logic                 commit_ok;
    logic                 commit_bad;
    logic                 wr_done_reg;
    logic [7:0]           err_cnt_reg;

    uart_frame_assembler #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .REG_W       (REG_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_asm (
        .clk          (clk),
        .reset        (reset),
        .byte_valid   (uart_rx_wr_en),
        .byte_data    (uart_rx_data),
        .frame_valid  (frame_valid),
        .frame_sel    (frame_sel),
        .frame_ch     (frame_ch),
        .frame_addr   (frame_addr),
        .frame_data   (frame_data),
        .chk_ok       (chk_ok),
        .timeout_drop (timeout_drop)
    );

    // A frame writes only if its target exists and no stray high address bits are set.
    assign addr_hi_zero = ((frame_addr >> ADDR_W) == '0);
    assign ch_ok        = (32'(frame_ch) < NUM_CH);
    assign reg_ok       = (32'(frame_addr) < NUM_REGS);
    assign commit_ok    = frame_valid && chk_ok && addr_hi_zero && (frame_sel ? reg_ok : ch_ok);
    assign commit_bad   = frame_valid && !commit_ok;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
            logic [DATA_W-1:0] rd_reg;
            logic              we;

            assign we = commit_ok && !frame_sel && (frame_ch == HDR_CH_W'(gi));

            // RAM write port; contents deliberately survive reset.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[frame_addr[ADDR_W-1:0]] <= frame_data[DATA_W-1:0];
                end
            end

            // Registered read port, read-first against a same-cycle write.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_reg <= '0;
                end else begin
                    rd_reg <= mem[seq_addr[gi*ADDR_W +: ADDR_W]];
                end
            end

            assign memout[gi*DATA_W +: DATA_W] = rd_reg;
        end

        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [REG_W-1:0] RST_VAL = (gi == 0) ? '0 : REG_W'(REG_DEFAULT);
            logic [REG_W-1:0] val_reg;

            // Register bank entry, updated on the commit edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    val_reg <= RST_VAL;
                end else if (commit_ok && frame_sel && (32'(frame_addr) == gi)) begin
                    val_reg <= frame_data[REG_W-1:0];
                end
            end

            assign reg_out[gi*REG_W +: REG_W] = val_reg;
        end
    endgenerate

    // Write-done strobe and saturating count of rejected or timed-out frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_done_reg <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            wr_done_reg <= commit_ok;
            if ((commit_bad || timeout_drop) && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign wr_done       = wr_done_reg;
    assign frame_err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_seq_memory_space.sv
// Directed bench for seq_memory_space: RAM and register writes, range
// errors, timeout resync, back-to-back frames and (with
// MEMSPACE_CHECKSUM_EN) checksum rejection.
module tb_seq_memory_space;

    localparam int NUM_CH   = 8;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 12;
    localparam int NUM_REGS = 9;
    localparam int REG_W    = 16;
    localparam int TMO      = 20;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      uart_rx_wr_en;
    logic [7:0]                uart_rx_data;
    logic [NUM_CH*ADDR_W-1:0]  seq_addr;
    logic [NUM_CH*DATA_W-1:0]  memout;
    logic [NUM_REGS*REG_W-1:0] reg_out;
    logic                      wr_done;
    logic [7:0]                frame_err_cnt;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;

    seq_memory_space #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
        .REG_W(REG_W), .REG_DEFAULT(10), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rx_wr_en (uart_rx_wr_en),
        .uart_rx_data  (uart_rx_data),
        .seq_addr      (seq_addr),
        .memout        (memout),
        .reg_out       (reg_out),
        .wr_done       (wr_done),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_done === 1'b1) wr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx_wr_en = 1'b1;
        uart_rx_data  = b;
        tick();
    endtask

    // One full frame on consecutive cycles; bad=1 corrupts the checksum byte.
    task automatic send_frame(input logic [7:0] h, input logic [7:0] a,
                              input logic [15:0] d, input bit bad);
        logic [7:0] x;
        x = h ^ a ^ d[15:8] ^ d[7:0];
        send_byte(h);
        send_byte(a);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
`ifdef MEMSPACE_CHECKSUM_EN
        send_byte(bad ? (x ^ 8'h01) : x);
`else
        if (bad) x = 8'h00;
`endif
        uart_rx_wr_en = 1'b0;
    endtask

    function automatic logic [31:0] mem_of(input int c);
        return 32'(memout[c*DATA_W +: DATA_W]);
    endfunction

    function automatic logic [31:0] reg_of(input int r);
        return 32'(reg_out[r*REG_W +: REG_W]);
    endfunction

    initial begin
        reset         = 1'b1;
        uart_rx_wr_en = 1'b0;
        uart_rx_data  = 8'h00;
        seq_addr      = '0;
        idle(3);
        reset = 1'b0;

        // Reset state
        check("rst_memout", 32'(memout == '0), 32'd1);
        check("rst_wr_done", 32'(wr_done), 32'd0);
        check("rst_err", 32'(frame_err_cnt), 32'd0);
        check("rst_reg0", reg_of(0), 32'd0);
        for (int r = 1; r < NUM_REGS; r++) check($sformatf("rst_reg%0d", r), reg_of(r), 32'd10);

        // RAM ch1 addr5 <= 0xABC, exact strobe and read latency
        seq_addr[1*ADDR_W +: ADDR_W] = 7'd5;
        send_frame(8'h01, 8'h05, 16'h0ABC, 1'b0);
        check("wd_before", 32'(wr_done), 32'd0);
        tick();
        check("wd_commit", 32'(wr_done), 32'd1);
        tick();
        check("wd_after", 32'(wr_done), 32'd0);
        check("ram_ch1_abc", mem_of(1), 32'hABC);
        check("wr_cnt1", 32'(wr_cnt), 32'd1);
        check("err_t1", 32'(frame_err_cnt), 32'd0);

        // Rewrite same address: old data visible on the write edge
        send_frame(8'h01, 8'h05, 16'h0DEF, 1'b0);
        tick();
        check("read_first", mem_of(1), 32'hABC);
        tick();
        check("ram_ch1_def", mem_of(1), 32'hDEF);

        // Register write reg3 <= 7, visible with wr_done
        send_frame(8'h83, 8'h00, 16'h0000, 1'b0);
        idle(1);
        send_frame(8'h80, 8'h03, 16'h0007, 1'b0);
        tick();
        check("reg_wd", 32'(wr_done), 32'd1);
        check("reg3", reg_of(3), 32'h0007);
        check("reg0_w", reg_of(0), 32'h0000);
        idle(2);
        check("reg4_keep", reg_of(4), 32'd10);
        check("wr_cnt_reg", 32'(wr_cnt), 32'd4);

        // Range errors: channel 9, register 9, stray address bit 7
        send_frame(8'h09, 8'h00, 16'h1234, 1'b0);
        idle(3);
        check("err_ch9", 32'(frame_err_cnt), 32'd1);
        send_frame(8'h80, 8'h09, 16'h1234, 1'b0);
        idle(3);
        check("err_reg9", 32'(frame_err_cnt), 32'd2);
        send_frame(8'h01, 8'h85, 16'h0999, 1'b0);
        idle(3);
        check("err_addrhi", 32'(frame_err_cnt), 32'd3);
        check("ram_ch1_kept", mem_of(1), 32'hDEF);
        check("wr_cnt_err", 32'(wr_cnt), 32'd4);

        // Timeout: 2 bytes then TMO idle cycles drops the partial frame
        send_byte(8'h02);
        send_byte(8'h07);
        uart_rx_wr_en = 1'b0;
        idle(TMO);
        seq_addr[2*ADDR_W +: ADDR_W] = 7'd7;
        send_frame(8'h02, 8'h07, 16'h0555, 1'b0);
        idle(3);
        check("err_tmo", 32'(frame_err_cnt), 32'd4);
        check("ram_ch2_555", mem_of(2), 32'h555);

        // One cycle short of the timeout: frame continues
        send_byte(8'h02);
        send_byte(8'h08);
        uart_rx_wr_en = 1'b0;
        idle(TMO - 1);
        send_byte(8'h03);
        send_byte(8'h33);
`ifdef MEMSPACE_CHECKSUM_EN
        send_byte(8'h3A);
`endif
        uart_rx_wr_en = 1'b0;
        seq_addr[2*ADDR_W +: ADDR_W] = 7'd8;
        idle(3);
        check("err_near_tmo", 32'(frame_err_cnt), 32'd4);
        check("ram_ch2_333", mem_of(2), 32'h333);
        check("wr_cnt_tmo", 32'(wr_cnt), 32'd6);

        // Back-to-back frames: second header lands in the COMMIT cycle
        seq_addr[3*ADDR_W +: ADDR_W] = 7'd1;
        seq_addr[4*ADDR_W +: ADDR_W] = 7'd2;
        send_frame(8'h03, 8'h01, 16'h0111, 1'b0);
        send_frame(8'h04, 8'h02, 16'h0222, 1'b0);
        idle(3);
        check("b2b_ch3", mem_of(3), 32'h111);
        check("b2b_ch4", mem_of(4), 32'h222);
        check("wr_cnt_b2b", 32'(wr_cnt), 32'd8);
        check("err_b2b", 32'(frame_err_cnt), 32'd4);

`ifdef MEMSPACE_CHECKSUM_EN
        // Corrupted checksum: no write, error counted
        send_frame(8'h03, 8'h01, 16'h0777, 1'b1);
        idle(3);
        check("chk_bad_keep", mem_of(3), 32'h111);
        check("chk_bad_err", 32'(frame_err_cnt), 32'd5);
        check("chk_bad_wd", 32'(wr_cnt), 32'd8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
